// File: rtl/vec_store_sequencer_pkg.sv
// Shared types and constants for the vector store sequencer.
// Lane count, widths, FSM state codes and small address helpers.
package vec_store_sequencer_pkg;

    localparam int NLANES = 5;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int STRIDE = 4;
    localparam int LW     = $clog2(NLANES + 1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    localparam logic [AW-1:0] STRIDE_W = AW'(STRIDE);
    localparam logic [LW-1:0] NLANES_W = LW'(NLANES);

    typedef logic [NLANES-1:0][DW-1:0] lane_arr_t;

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        return (len > NLANES_W) ? NLANES_W : len;
    endfunction

    // Byte offset of a lane from the burst base; wraps modulo 2^AW.
    function automatic logic [AW-1:0] lane_off(input logic [LW-1:0] idx);
        return AW'(idx) * STRIDE_W;
    endfunction

endpackage

// File: rtl/vec_store_sequencer_lane_mux.sv
// NLANES:1 select over the latched lane registers.
// Driven by the burst index; out-of-range selects yield zero.
module vec_store_sequencer_lane_mux
    import vec_store_sequencer_pkg::*;
(
    input  lane_arr_t       lanes,
    input  logic [LW-1:0]   sel,
    output logic [DW-1:0]   data
);

    always_comb begin
        data = '0;
        for (int i = 0; i < NLANES; i++) begin
            if (sel == LW'(i)) begin
                data = lanes[i];
            end
        end
    end

endmodule

// File: rtl/vec_store_sequencer.sv
// Arbitrates the single dmem write port between scalar and vector stores.
// Vector lanes are latched in one cycle and written out one word per cycle.
module vec_store_sequencer
    import vec_store_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wd,
    input  logic          vec_req,
    input  logic [AW-1:0] vec_base,
    input  logic [LW-1:0] vec_len,
    input  logic [DW-1:0] vec_wd_0,
    input  logic [DW-1:0] vec_wd_1,
    input  logic [DW-1:0] vec_wd_2,
    input  logic [DW-1:0] vec_wd_3,
    input  logic [DW-1:0] vec_wd_4,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    output logic          stall,
    output logic          vec_done,
    output logic          seq_err
);

    logic          state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    lane_arr_t     data_q, data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    lane_arr_t     lanes_in;
    logic [DW-1:0] lane_data;
    logic          we_c;

    assign lanes_in = {vec_wd_4, vec_wd_3, vec_wd_2, vec_wd_1, vec_wd_0};

    vec_store_sequencer_lane_mux u_lane_mux (
        .lanes (data_q),
        .sel   (idx_q),
        .data  (lane_data)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (vec_req) begin
                    if (vec_len > NLANES_W) begin
                        err_d = 1'b1;
                    end
                    if (vec_len != '0) begin
                        base_d  = vec_base;
                        len_d   = clamp_len(vec_len);
                        idx_d   = '0;
                        data_d  = lanes_in;
                        state_d = ST_BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                idx_d = idx_q + LW'(1);
                // A second request cannot be queued; flag it and carry on.
                if (vec_req) begin
                    err_d = 1'b1;
                end
                if (idx_q == len_q - LW'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        we_c     = core_we;
        mem_addr = core_addr;
        mem_wd   = core_wd;
        stall    = 1'b0;
        if (state_q == ST_BURST) begin
            we_c     = 1'b1;
            mem_addr = base_q + lane_off(idx_q);
            mem_wd   = lane_data;
            stall    = 1'b1;
        end
        mem_we = we_c & reset;
    end

    assign vec_done = done_q;
    assign seq_err  = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Lane payload needs no reset: it is only read while bursting.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: tb/tb_vec_store_sequencer.sv
// Bench for vec_store_sequencer: queue-based write model plus
// directed scenarios with literal expectations.
module tb_vec_store_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic        vec_req;
    logic [31:0] vec_base;
    logic [2:0]  vec_len;
    logic [31:0] vwd [5];
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        stall;
    logic        vec_done;
    logic        seq_err;

    int checks = 0;
    int errs   = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t q[$];
    bit  m_done = 1'b0;
    bit  m_err  = 1'b0;
    bit  armed  = 1'b0;

    always #5 clk = ~clk;

    vec_store_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .core_we   (core_we),
        .core_addr (core_addr),
        .core_wd   (core_wd),
        .vec_req   (vec_req),
        .vec_base  (vec_base),
        .vec_len   (vec_len),
        .vec_wd_0  (vwd[0]),
        .vec_wd_1  (vwd[1]),
        .vec_wd_2  (vwd[2]),
        .vec_wd_3  (vwd[3]),
        .vec_wd_4  (vwd[4]),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .stall     (stall),
        .vec_done  (vec_done),
        .seq_err   (seq_err)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: a burst is just a list of pending (addr, data) writes.
    always @(posedge clk) begin
        int n;
        if (!reset) begin
            q.delete();
            m_done = 1'b0;
            m_err  = 1'b0;
            armed  = 1'b1;
        end else if (q.size() != 0) begin
            void'(q.pop_front());
            m_done = (q.size() == 0);
            if (vec_req) m_err = 1'b1;
        end else begin
            m_done = 1'b0;
            if (vec_req) begin
                n = (vec_len > 3'd5) ? 5 : int'(vec_len);
                if (vec_len > 3'd5) m_err = 1'b1;
                if (n == 0) m_done = 1'b1;
                for (int i = 0; i < n; i++) begin
                    q.push_back({vec_base + 32'(4 * i), vwd[i]});
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_we;
        if (armed) begin
            exp_we = reset && (q.size() != 0 || core_we);
            chk("m.mem_we", {31'd0, mem_we}, {31'd0, exp_we});
            if (exp_we) begin
                chk("m.mem_addr", mem_addr, (q.size() != 0) ? q[0].a : core_addr);
                chk("m.mem_wd", mem_wd, (q.size() != 0) ? q[0].d : core_wd);
            end
            chk("m.stall", {31'd0, stall}, {31'd0, q.size() != 0});
            chk("m.vec_done", {31'd0, vec_done}, {31'd0, m_done});
            chk("m.seq_err", {31'd0, seq_err}, {31'd0, m_err});
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        core_we   = 1'b0;
        core_addr = 32'h0;
        core_wd   = 32'h0;
        vec_req   = 1'b0;
        vec_base  = 32'h0;
        vec_len   = 3'd0;
    endtask

    task automatic req(input logic [31:0] base, input logic [2:0] len,
                       input logic [31:0] d0);
        vec_req  = 1'b1;
        vec_base = base;
        vec_len  = len;
        for (int i = 0; i < 5; i++) vwd[i] = d0 + 32'(i);
    endtask

    initial begin
        reset = 1'b0;
        quiet();
        for (int i = 0; i < 5; i++) vwd[i] = 32'h0;
        nxt();
        nxt();
        @(negedge clk);
        chk("rst.mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst.stall", {31'd0, stall}, 32'd0);
        chk("rst.vec_done", {31'd0, vec_done}, 32'd0);
        chk("rst.seq_err", {31'd0, seq_err}, 32'd0);
        nxt();
        reset = 1'b1;

        // T1 scalar pass-through
        core_we = 1'b1; core_addr = 32'h64; core_wd = 32'h7;
        @(negedge clk);
        chk("t1.mem_we", {31'd0, mem_we}, 32'd1);
        chk("t1.mem_addr", mem_addr, 32'h64);
        chk("t1.mem_wd", mem_wd, 32'h7);
        chk("t1.stall", {31'd0, stall}, 32'd0);
        nxt();
        quiet();

        // T2 full vector
        req(32'h100, 3'd5, 32'hA);
        nxt();
        quiet();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2.stall", {31'd0, stall}, 32'd1);
            chk("t2.addr", mem_addr, 32'h100 + 32'(4 * i));
            chk("t2.wd", mem_wd, 32'hA + 32'(i));
            nxt();
        end
        @(negedge clk);
        chk("t2.done", {31'd0, vec_done}, 32'd1);
        chk("t2.stall_end", {31'd0, stall}, 32'd0);
        nxt();

        // T3 zero length, then over-length clamp
        req(32'h200, 3'd0, 32'h1);
        nxt();
        quiet();
        @(negedge clk);
        chk("t3.len0_done", {31'd0, vec_done}, 32'd1);
        chk("t3.len0_we", {31'd0, mem_we}, 32'd0);
        nxt();
        req(32'h300, 3'd7, 32'h50);
        nxt();
        quiet();
        repeat (5) nxt();
        @(negedge clk);
        chk("t3.clamp_done", {31'd0, vec_done}, 32'd1);
        chk("t3.seq_err", {31'd0, seq_err}, 32'd1);
        nxt();
        reset = 1'b0;
        nxt();
        reset = 1'b1;

        // T4 address wrap
        req(32'hFFFF_FFF8, 3'd3, 32'h77);
        nxt();
        quiet();
        @(negedge clk); chk("t4.a0", mem_addr, 32'hFFFF_FFF8); nxt();
        @(negedge clk); chk("t4.a1", mem_addr, 32'hFFFF_FFFC); nxt();
        @(negedge clk); chk("t4.a2", mem_addr, 32'h0000_0000); nxt();
        nxt();

        // T5 reset during the second lane
        req(32'h400, 3'd5, 32'h90);
        nxt();
        quiet();
        nxt();
        reset = 1'b0;
        @(negedge clk);
        chk("t5.mem_we", {31'd0, mem_we}, 32'd0);
        nxt();
        reset = 1'b1;
        @(negedge clk);
        chk("t5.stall", {31'd0, stall}, 32'd0);
        chk("t5.seq_err", {31'd0, seq_err}, 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("t5.no_done", {31'd0, vec_done}, 32'd0);
            nxt();
        end

        // T6 request with scalar in same cycle, then request during burst
        req(32'h500, 3'd3, 32'hC0);
        core_we = 1'b1; core_addr = 32'h44; core_wd = 32'h55;
        @(negedge clk);
        chk("t6.scalar_we", {31'd0, mem_we}, 32'd1);
        chk("t6.scalar_addr", mem_addr, 32'h44);
        nxt();
        quiet();
        nxt();
        req(32'h900, 3'd2, 32'hEE);
        nxt();
        quiet();
        @(negedge clk);
        chk("t6.addr2", mem_addr, 32'h508);
        chk("t6.wd2", mem_wd, 32'hC2);
        nxt();
        @(negedge clk);
        chk("t6.done", {31'd0, vec_done}, 32'd1);
        chk("t6.seq_err", {31'd0, seq_err}, 32'd1);
        repeat (3) nxt();
        @(negedge clk);
        chk("t6.err_sticky", {31'd0, seq_err}, 32'd1);
        chk("t6.idle", {31'd0, stall}, 32'd0);
        nxt();
        reset = 1'b0;
        nxt();
        reset = 1'b1;
        @(negedge clk);
        chk("t6.err_clr", {31'd0, seq_err}, 32'd0);
        nxt();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
